band_energy_meter: RTL and testbench
====================================

Name: band_energy_meter

Overview:
Sits directly downstream of the 8-channel polyphase filter bank. On every din_enable, it captures the eight filter outputs, which still hold the final results of the previous sample. It then squares each channel on one time-shared multiplier and updates a per-band leaky-integrated energy. The eight band energies are emitted as a valid/ready stream to the spectrum/AGC logic.

Parameters:
LEAK_SHIFT, 6, integrator decay, applied as e - (e >>> LEAK_SHIFT); legal range 1..12
EW, 40, energy register width (unsigned); fixed at 40, not overridden

Ports:
clock  in  1  master clock, rising edge
reset  in  1  master reset, asynchronous, active high
din_enable  in  1  same strobe that feeds the filter bank; 1-cycle pulse per input sample
band0..band7  in  16 each  signed filter-bank outputs dataout0..dataout7
energy_clear  in  1  synchronous clear of all eight energies
out_valid  out  1  stream beat valid
out_ready  in  1  consumer accepts the beat
out_band  out  3  band index of the current beat
out_energy  out  32  energy of band out_band, equal to e[39:8]
overrun  out  1  sticky; set when din_enable arrives while CALC or EMIT is in progress
busy  out  1  high in CALC and EMIT

Behaviour:
- Reset (async): all eight e registers = 0, captured samples = 0, state = IDLE, out_valid = 0, out_band = 0, out_energy = 0, overrun = 0, busy = 0.
- FSM states: IDLE, CALC, EMIT.
- Capture on din_enable in any state at edge T:
  - band0..7 are latched into cap[0..7].
  - ch is set to 0 and state goes to CALC.
  - If the state was CALC or EMIT, overrun is set and any unfinished emission is discarded; out_valid drops the cycle after.
- CALC runs cycles T+1..T+8, one channel per cycle:
  - sq = cap[ch]*cap[ch], 32-bit unsigned; maximum 2^30.
  - The update is computed in 41 bits: n = e[ch] - (e[ch] >> LEAK_SHIFT) + sq.
  - e[ch] <= (n > 2^40-1) ? 2^40-1 : n, i.e. saturating.
  - ch increments; after ch = 7 the FSM goes to EMIT with ch = 0.
- EMIT:
  - out_valid = 1, out_band = ch, out_energy = e[ch][39:8].
  - The beat completes on out_valid & out_ready, and ch then increments.
  - Once ch = 7 is accepted, the FSM returns to IDLE and out_valid = 0.
  - out_band and out_energy are held stable while out_valid & !out_ready.
- Latency: with out_ready held high, band 0 is presented at T+9 and band 7 at T+16; the FSM is idle at T+17. This is well inside the 67+ cycle sample period of the filter bank.
- energy_clear:
  - Takes priority over CALC updates: all e = 0 and the FSM returns to IDLE, aborting any emission.
  - If din_enable arrives in the same cycle, the capture still happens and CALC starts from zero energies.
  - energy_clear does not clear overrun.
- overrun is cleared only by reset.
- din_enable while IDLE never sets overrun.

Optional Feature:
Macro PEAK_BAND_EN.
- When defined, adds two outputs: peak_band (out, 3) and peak_valid (out, 1).
- At the last CALC cycle, the block registers the index of the largest updated e; ties go to the lowest index.
- peak_valid pulses for 1 cycle, coincident with the first EMIT cycle.
- Both outputs reset to 0, and an aborted CALC produces no pulse.
- When undefined, neither port exists and there is no comparison logic.

Test Plan:
1. Reset, then band0 = 16384 with the others 0, din_enable once, out_ready = 1. Required: beats 0..7 appear at T+9..T+16, band 0 energy = 1048576, the rest 0.
2. Same input, second din_enable. Required: band 0 energy = 2080768. After 400 samples, band 0 converges to 67108864 ±1%.
3. LEAK_SHIFT = 10, band3 = -32768 held for 20000 samples. Required: band 3 energy saturates at 4294967295 and never wraps.
4. out_ready low for 5 cycles at band 2. Required: out_band = 2 and out_energy are held stable, the beat is accepted on the first ready cycle, and no beat is lost or duplicated.
5. din_enable asserted during EMIT band 4. Required: overrun = 1, the stream restarts at band 0 nine cycles later, and overrun stays 1 through the next IDLE.
6. energy_clear mid-CALC, then assert reset asynchronously between clock edges mid-EMIT. Required:
   - after the clear: FSM in IDLE, the next sample energies equal the first-sample values of scenario 1;
   - after reset: out_valid, busy and overrun go to 0 immediately, without waiting for a clock edge.
   - Under PEAK_BAND_EN, scenario 1 additionally gives peak_band = 0 with peak_valid at T+9.

Source files
------------

// File: rtl/band_energy_meter.sv
// -----------------------------------------------------------------------------
// band_energy_meter
//
// Per-band leaky-integrated energy meter for the 8-channel polyphase filter
// bank. Each din_enable captures the eight filter outputs (they still hold the
// previous sample's final results). A single time-shared squarer then updates
// one band energy per cycle over eight cycles. The eight energies are then
// streamed out as valid/ready beats, band 0 first.
//
// Energy update per band (41-bit intermediate, saturating to EW bits):
//   e <= sat(e - (e >> LEAK_SHIFT) + band*band)
//
// Ports
//   clock         in   master clock, rising edge
//   reset         in   asynchronous, active-high master reset
//   din_enable    in   1-cycle strobe per input sample (same as filter bank)
//   band0..band7  in   signed 16-bit filter-bank outputs
//   energy_clear  in   synchronous clear of all energies; aborts CALC/EMIT
//   out_valid     out  stream beat valid (EMIT state)
//   out_ready     in   consumer accepts the beat
//   out_band      out  band index of the current beat
//   out_energy    out  e[out_band][39:8]
//   overrun       out  sticky: a sample arrived while CALC/EMIT was running
//   busy          out  high in CALC and EMIT
//
// Optional build macro PEAK_BAND_EN adds:
//   peak_band     out  index of the largest energy after the last CALC step
//                      (ties resolve to the lowest index)
//   peak_valid    out  1-cycle pulse coincident with the first EMIT cycle
// -----------------------------------------------------------------------------
module band_energy_meter #(
  parameter int LEAK_SHIFT = 6,
  parameter int EW         = 40
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               din_enable,
  input  logic signed [15:0] band0,
  input  logic signed [15:0] band1,
  input  logic signed [15:0] band2,
  input  logic signed [15:0] band3,
  input  logic signed [15:0] band4,
  input  logic signed [15:0] band5,
  input  logic signed [15:0] band6,
  input  logic signed [15:0] band7,
  input  logic               energy_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_band,
  output logic [31:0]        out_energy,
  output logic               overrun,
`ifdef PEAK_BAND_EN
  output logic [2:0]         peak_band,
  output logic               peak_valid,
`endif
  output logic               busy
);

  localparam int DATA_W = 16;
  localparam int SQ_W   = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                ch_q, ch_d;
  logic                      overrun_q, overrun_d;
  logic signed [DATA_W-1:0]  cap_q [8];
  logic signed [DATA_W-1:0]  cap_d [8];
  logic [EW-1:0]             e_q   [8];
  logic [EW-1:0]             e_d   [8];

  // Clamp the 41-bit update back into the EW-bit register. The worst case is
  // (2^EW - 1) + 2^30, so only the single carry bit can be set on overflow.
  function automatic logic [EW-1:0] sat_energy(input logic [EW:0] n);
    return n[EW] ? {EW{1'b1}} : n[EW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Time-shared squarer and leaky-integrator update for channel ch_q
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] cap_sel;
  logic signed [SQ_W-1:0]   cap_ext;
  logic signed [SQ_W-1:0]   sq_s;
  logic [SQ_W-1:0]          sq;
  logic [EW-1:0]            e_sel;
  logic [EW:0]              n_upd;
  logic [EW-1:0]            e_new;

  always_comb begin
    cap_sel = cap_q[ch_q];
    cap_ext = SQ_W'(cap_sel);
    sq_s    = cap_ext * cap_ext;
    // A square is never negative; the largest value is (-32768)^2 = 2^30.
    sq      = unsigned'(sq_s);
    e_sel   = e_q[ch_q];
    n_upd   = {1'b0, e_sel} - {1'b0, (e_sel >> LEAK_SHIFT)}
            + {{(EW + 1 - SQ_W){1'b0}}, sq};
    e_new   = sat_energy(n_upd);
  end

  // ---------------------------------------------------------------------------
  // FSM next state, channel counter, capture and energy registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    overrun_d = overrun_q;
    for (int i = 0; i < 8; i++) begin
      cap_d[i] = cap_q[i];
      e_d[i]   = e_q[i];
    end

    case (state_q)
      CALC: begin
        e_d[ch_q] = e_new;
        if (ch_q == 3'd7) begin
          state_d = EMIT;
          ch_d    = 3'd0;
        end else begin
          ch_d = ch_q + 3'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (ch_q == 3'd7) begin
            state_d = IDLE;
            ch_d    = 3'd0;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
      end
      default: ;
    endcase

    // Clear wins over any CALC write in the same cycle.
    if (energy_clear) begin
      for (int i = 0; i < 8; i++) begin
        e_d[i] = '0;
      end
      state_d = IDLE;
      ch_d    = 3'd0;
    end

    // A new sample always restarts the pass, even after a same-cycle clear,
    // so CALC then begins from zero energies.
    if (din_enable) begin
      cap_d[0] = band0;
      cap_d[1] = band1;
      cap_d[2] = band2;
      cap_d[3] = band3;
      cap_d[4] = band4;
      cap_d[5] = band5;
      cap_d[6] = band6;
      cap_d[7] = band7;
      state_d  = CALC;
      ch_d     = 3'd0;
      if (state_q != IDLE) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ch_q      <= 3'd0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cap_q[i] <= '0;
        e_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < 8; i++) begin
        cap_q[i] <= cap_d[i];
        e_q[i]   <= e_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stream outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid  = (state_q == EMIT);
    busy       = (state_q != IDLE);
    overrun    = overrun_q;
    out_band   = out_valid ? ch_q : 3'd0;
    out_energy = out_valid ? e_sel[EW-1:EW-32] : 32'd0;
  end

`ifdef PEAK_BAND_EN
  // ---------------------------------------------------------------------------
  // Peak-band search, evaluated on the last CALC step using the freshly
  // updated channel-7 value in place of its register.
  // ---------------------------------------------------------------------------
  logic [2:0]    peak_band_q, peak_band_d;
  logic          peak_valid_q, peak_valid_d;
  logic [EW-1:0] pk_best;
  logic [EW-1:0] pk_cand;
  logic [2:0]    pk_idx;
  logic          pk_fire;

  always_comb begin
    pk_best = (ch_q == 3'd0) ? e_new : e_q[0];
    pk_cand = '0;
    pk_idx  = 3'd0;
    for (int i = 1; i < 8; i++) begin
      pk_cand = (ch_q == 3'(i)) ? e_new : e_q[i];
      // Strictly greater keeps the lowest index on ties.
      if (pk_cand > pk_best) begin
        pk_best = pk_cand;
        pk_idx  = 3'(i);
      end
    end

    // A pass cut short by a clear or a new sample never reaches EMIT.
    pk_fire      = (state_q == CALC) && (ch_q == 3'd7) && !energy_clear && !din_enable;
    peak_valid_d = pk_fire;
    peak_band_d  = pk_fire ? pk_idx : peak_band_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      peak_band_q  <= 3'd0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_band_q  <= peak_band_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign peak_band  = peak_band_q;
  assign peak_valid = peak_valid_q;
`endif

endmodule

// File: tb/tb_band_energy_meter.sv
// -----------------------------------------------------------------------------
// tb_band_energy_meter
//
// Directed bench for band_energy_meter. dut drives the main scenarios with the
// default LEAK_SHIFT = 6. dut_sat uses LEAK_SHIFT = 12 so that the band-3
// saturation point (steady state 2^42 > 2^40) is reached within ~1200 samples.
// Beats are logged one time unit before each rising edge.
// -----------------------------------------------------------------------------
module tb_band_energy_meter;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               din_enable = 1'b0;
  logic signed [15:0] b [8];
  logic               energy_clear = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [2:0]         out_band;
  logic [31:0]        out_energy;
  logic               overrun;
  logic               busy;

  logic               din2 = 1'b0;
  logic signed [15:0] b2 [8];
  logic               ov2;
  logic [2:0]         ob2;
  logic [31:0]        oe2;
  logic               ovr2;
  logic               busy2;

`ifdef PEAK_BAND_EN
  logic [2:0] peak_band;
  logic       peak_valid;
  logic [2:0] peak_band2;
  logic       peak_valid2;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  band_energy_meter dut (
    .clock(clock), .reset(reset), .din_enable(din_enable),
    .band0(b[0]), .band1(b[1]), .band2(b[2]), .band3(b[3]),
    .band4(b[4]), .band5(b[5]), .band6(b[6]), .band7(b[7]),
    .energy_clear(energy_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_band(out_band), .out_energy(out_energy), .overrun(overrun),
`ifdef PEAK_BAND_EN
    .peak_band(peak_band), .peak_valid(peak_valid),
`endif
    .busy(busy)
  );

  band_energy_meter #(.LEAK_SHIFT(12)) dut_sat (
    .clock(clock), .reset(reset), .din_enable(din2),
    .band0(b2[0]), .band1(b2[1]), .band2(b2[2]), .band3(b2[3]),
    .band4(b2[4]), .band5(b2[5]), .band6(b2[6]), .band7(b2[7]),
    .energy_clear(1'b0), .out_valid(ov2), .out_ready(1'b1),
    .out_band(ob2), .out_energy(oe2), .overrun(ovr2),
`ifdef PEAK_BAND_EN
    .peak_band(peak_band2), .peak_valid(peak_valid2),
`endif
    .busy(busy2)
  );

  // Beat log for dut, sampled 1 time unit before the rising edge.
  logic        beat_clr = 1'b0;
  int          beat_n = 0;
  logic [2:0]  beat_band   [16];
  logic [31:0] beat_energy [16];
  int          beat_cyc    [16];
  int          pk_cyc = -1;
  logic [2:0]  pk_band = 3'd0;

  always @(negedge clock) begin
    #4;
    if (beat_clr) begin
      beat_n <= 0;
      pk_cyc <= -1;
    end else begin
      if (out_valid && out_ready) begin
        if (beat_n < 16) begin
          beat_band[beat_n]   <= out_band;
          beat_energy[beat_n] <= out_energy;
          beat_cyc[beat_n]    <= cyc;
        end
        beat_n <= beat_n + 1;
      end
`ifdef PEAK_BAND_EN
      if (peak_valid) begin
        pk_cyc  <= cyc;
        pk_band <= peak_band;
      end
`endif
    end
  end

  // Band-3 tracker for dut_sat: last value and any decrease (wrap).
  logic [31:0] last3 = 32'd0;
  logic        wrap3 = 1'b0;

  always @(negedge clock) begin
    #4;
    if (ov2 && (ob2 == 3'd3)) begin
      if (oe2 < last3) wrap3 <= 1'b1;
      last3 <= oe2;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_beats();
    @(negedge clock); beat_clr = 1'b1;
    @(negedge clock); beat_clr = 1'b0;
  endtask

  // Returns at the negedge following edge T, where T is the capture edge.
  task automatic pulse_din(output int t);
    @(negedge clock); din_enable = 1'b1; t = cyc;
    @(negedge clock); din_enable = 1'b0;
  endtask

  task automatic pulse_din2();
    @(negedge clock); din2 = 1'b1;
    @(negedge clock); din2 = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k = 0;
    while (beat_n < n && k < 60) begin
      @(negedge clock); k++;
    end
    chk(tag, 64'(beat_n >= n), 64'd1);
  endtask

  task automatic wait_band(input logic [2:0] bnd, input string tag);
    int k = 0;
    while (!(out_valid && out_band == bnd) && k < 40) begin
      @(negedge clock); k++;
    end
    chk(tag, 64'(out_valid && out_band == bnd), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    logic [31:0] hold;

    for (int i = 0; i < 8; i++) begin
      b[i]  = 16'sd0;
      b2[i] = 16'sd0;
    end

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_busy",       busy,       0);
    chk("rst_overrun",    overrun,    0);
    chk("rst_out_band",   out_band,   0);
    chk("rst_out_energy", out_energy, 0);

    // Scenario 1: single sample on band 0, check latency and energies
    b[0] = 16'sd16384;
    clear_beats();
    pulse_din(t0);
    wait_beats(8, "s1_beats_done");
    chk("s1_band0_cycle", beat_cyc[0], t0 + 9);
    chk("s1_band7_cycle", beat_cyc[7], t0 + 16);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s1_beat%0d_band", i), beat_band[i], i);
      chk($sformatf("s1_beat%0d_energy", i), beat_energy[i], (i == 0) ? 1048576 : 0);
    end
    chk("s1_idle_busy", busy, 0);
`ifdef PEAK_BAND_EN
    chk("s1_peak_cycle", pk_cyc, t0 + 9);
    chk("s1_peak_band",  pk_band, 0);
`endif

    // Scenario 2: second sample, then converge over 400 samples total
    clear_beats();
    pulse_din(t0);
    wait_beats(8, "s2_beats_done");
    chk("s2_band0_energy", beat_energy[0], 2080768);
    for (int s = 0; s < 397; s++) begin
      pulse_din(t0);
      repeat (18) @(negedge clock);
    end
    clear_beats();
    pulse_din(t0);
    wait_beats(8, "s2_last_beats_done");
    chk("s2_converge_1pct",
        64'((beat_energy[0] >= 32'd66437776) && (beat_energy[0] <= 32'd67779952)), 64'd1);
    chk("s2_no_overrun", overrun, 0);

    // Scenario 3: full-scale negative input on band 3 of dut_sat
    b2[3] = -16'sd32768;
    pulse_din2();
    repeat (18) @(negedge clock);
    chk("s3_first_energy", last3, 4194304);
    for (int s = 1; s < 1400; s++) begin
      pulse_din2();
      repeat (17) @(negedge clock);
    end
    chk("s3_saturated", last3, 32'hFFFF_FFFF);
    chk("s3_never_wraps", wrap3, 0);
    chk("s3_no_overrun", ovr2, 0);

    // Scenario 4: back-pressure for 5 cycles on band 2
    b[0] = 16'sd0;
    b[2] = 16'sd1000;
    clear_beats();
    pulse_din(t0);
    wait_band(3'd2, "s4_reach_band2");
    out_ready = 1'b0;
    hold = out_energy;
    chk("s4_band2_energy", hold, 3906);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("s4_hold%0d_band", k), out_band, 2);
      chk($sformatf("s4_hold%0d_energy", k), out_energy, hold);
    end
    out_ready = 1'b1;
    wait_beats(8, "s4_beats_done");
    chk("s4_band2_accept_cycle", beat_cyc[2], t0 + 16);
    chk("s4_band7_cycle", beat_cyc[7], t0 + 21);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s4_beat%0d_band", i), beat_band[i], i);
    end
    repeat (3) @(negedge clock);
    chk("s4_no_duplicate", beat_n, 8);
    chk("s4_no_overrun", overrun, 0);

    // Scenario 5: new sample during EMIT of band 4
    clear_beats();
    pulse_din(t0);
    wait_band(3'd4, "s5_reach_band4");
    out_ready  = 1'b0;
    din_enable = 1'b1;
    t1 = cyc;
    @(negedge clock);
    din_enable = 1'b0;
    out_ready  = 1'b1;
    chk("s5_overrun_set", overrun, 1);
    chk("s5_valid_dropped", out_valid, 0);
    chk("s5_beats_before", beat_n, 4);
    wait_beats(12, "s5_restart_done");
    chk("s5_restart_band", beat_band[4], 0);
    chk("s5_restart_cycle", beat_cyc[4], t1 + 9);
    chk("s5_last_band", beat_band[11], 7);
    chk("s5_idle_busy", busy, 0);
    chk("s5_overrun_sticky", overrun, 1);

    // Scenario 6: clear mid-CALC, then async reset mid-EMIT
    for (int i = 0; i < 8; i++) b[i] = 16'sd0;
    b[0] = 16'sd16384;
    clear_beats();
    pulse_din(t0);
    repeat (3) @(negedge clock);
    energy_clear = 1'b1;
    @(negedge clock);
    energy_clear = 1'b0;
    chk("s6_clear_idle", busy, 0);
    chk("s6_clear_no_valid", out_valid, 0);
    chk("s6_clear_keeps_overrun", overrun, 1);
    repeat (15) @(negedge clock);
    chk("s6_clear_no_beats", beat_n, 0);
    pulse_din(t0);
    wait_band(3'd3, "s6_reach_band3");
    chk("s6_band0_energy", beat_energy[0], 1048576);
    chk("s6_band1_energy", beat_energy[1], 0);
    chk("s6_band2_energy", beat_energy[2], 0);
    #2 reset = 1'b1;
    #1;
    chk("s6_async_valid",   out_valid,  0);
    chk("s6_async_busy",    busy,       0);
    chk("s6_async_overrun", overrun,    0);
    chk("s6_async_energy",  out_energy, 0);
    @(negedge clock);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
